// File: rtl/pi1_sram_slv_pkg.sv
// pi1 link constants and helpers shared by the SRAM responder and its sub-module.
package pi1_sram_slv_pkg;

    // pi1 operation encodings
    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    // Responder FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Wait-counter width; at least one bit so a zero-wait build still has a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pi1_sram_slv_lfsr.sv
// Pseudo-random stall source for the pi1 SRAM responder.
// Only compiled when PI1_SRAM_SLV_STALL_EN is defined.
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
`ifdef PI1_SRAM_SLV_STALL_EN
module pi1_sram_slv_lfsr (
    input  logic clk_i,
    input  logic rst_i,
    output logic stall_o
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // Next LFSR value: taps at bits 16,14,13,11 (1-based).
    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    // LFSR register, steps every cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_o = (lfsr_q[1:0] == 2'b00);
endmodule
`endif

// File: rtl/pi1_sram_slv.sv
// pi1 responder in front of an on-chip word-addressed SRAM.
// Serves PINOOP/PIWROP/PIRDOP/PIRWOP with byte selects and WAITCYCLES read wait-states.
// Optional feature: define PI1_SRAM_SLV_STALL_EN to insert pseudo-random idle stalls.
module pi1_sram_slv
    import pi1_sram_slv_pkg::*;
#(
    parameter  int ARCHBITSZ  = 32,
    parameter  int SIZE       = 1024,
    parameter  int WAITCYCLES = 1,
    localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o
);
    localparam int SELW = ARCHBITSZ / 8;
    localparam int IDXW = $clog2(SIZE);
    localparam int CNTW = cnt_width(WAITCYCLES);

    logic [ARCHBITSZ-1:0] mem [SIZE];

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 rdy_q, rdy_d;
    logic                 resp;
    logic                 stall;
    logic                 accept;
    logic                 is_rd;
    logic                 is_wr;
    logic [IDXW-1:0]      idx;
    logic [ARCHBITSZ-1:0] data_q;

    // Upper address bits alias onto the array and are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^pi1_addr_i[ADDRBITSZ-1:IDXW];

`ifdef PI1_SRAM_SLV_STALL_EN
    logic lfsr_stall;
    pi1_sram_slv_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_o (lfsr_stall)
    );
    assign stall = (state_q == ST_IDLE) && lfsr_stall;
`else
    assign stall = 1'b0;
`endif

    assign pi1_rdy_o  = rdy_q && !stall;
    assign pi1_data_o = data_q;
    assign idx        = pi1_addr_i[IDXW-1:0];
    assign is_rd      = (pi1_op_i == PIRDOP) || (pi1_op_i == PIRWOP);
    assign is_wr      = (pi1_op_i == PIWROP) || (pi1_op_i == PIRWOP);
    assign accept     = pi1_rdy_o && (pi1_op_i != PINOOP);

    // Next-state logic: reads with wait-states park in WAIT while the counter drains.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_rd && (WAITCYCLES > 0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNTW'(WAITCYCLES - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    resp    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    // FSM, wait counter and ready register; ready comes up on the first edge after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    // Byte-masked array write at the accept edge; array contents are never reset.
    always_ff @(posedge clk_i) begin
        if (accept && is_wr) begin
            for (int b = 0; b < SELW; b++) begin
                if (pi1_sel_i[b]) begin
                    mem[idx][b*8 +: 8] <= pi1_data_i[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (WAITCYCLES == 0) begin : g_nowait
            // Zero-wait: the registered read is the response, valid the cycle after accept.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    data_q <= '0;
                end else if (accept && is_rd) begin
                    data_q <= mem[idx];
                end
            end
            logic unused_resp;
            assign unused_resp = resp;
        end else begin : g_wait
            logic [ARCHBITSZ-1:0] rd_q;
            // Registered read captures the pre-write word at the accept edge.
            always_ff @(posedge clk_i) begin
                if (accept && is_rd) begin
                    rd_q <= mem[idx];
                end
            end
            // Output register only updates when the wait expires, so it holds the previous result meanwhile.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    data_q <= '0;
                end else if (resp) begin
                    data_q <= rd_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pi1_sram_slv.sv
// Directed self-checking bench for pi1_sram_slv: one WAITCYCLES=2 instance and one WAITCYCLES=0 instance.
module tb_pi1_sram_slv;
    localparam int AW = 30;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  op2, op0;
    logic [AW-1:0] addr2, addr0;
    logic [31:0] wdata2, wdata0, rdata2, rdata0;
    logic [3:0]  sel2, sel0;
    logic        rdy2, rdy0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pi1_sram_slv #(.ARCHBITSZ(32), .SIZE(1024), .WAITCYCLES(2)) u_dut2 (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .pi1_op_i   (op2),
        .pi1_addr_i (addr2),
        .pi1_data_i (wdata2),
        .pi1_data_o (rdata2),
        .pi1_sel_i  (sel2),
        .pi1_rdy_o  (rdy2)
    );

    pi1_sram_slv #(.ARCHBITSZ(32), .SIZE(1024), .WAITCYCLES(0)) u_dut0 (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .pi1_op_i   (op0),
        .pi1_addr_i (addr0),
        .pi1_data_i (wdata0),
        .pi1_data_o (rdata0),
        .pi1_sel_i  (sel0),
        .pi1_rdy_o  (rdy0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op to the WAITCYCLES=2 instance for a single accept edge.
    task automatic issue2(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        op2 = op; addr2 = a; wdata2 = d; sel2 = s;
        tick();
        op2 = 2'b00;
    endtask

    // Issue an op, then count rdy-low cycles until ready returns (bounded), and check the response.
    task automatic txn2(input string tag, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int exp_lows, input logic [31:0] exp_data);
        int   lows;
        logic got;
        lows = 0;
        got  = 1'b0;
        issue2(op, a, d, s);
        for (int i = 0; i < 8; i++) begin
            if (rdy2 === 1'b1) begin
                got = 1'b1;
                break;
            end
            lows++;
            tick();
        end
        check({tag, "_rdy"},   64'(got), 64'd1);
        check({tag, "_lows"},  64'(lows), 64'(exp_lows));
        check({tag, "_data"},  64'(rdata2), 64'(exp_data));
    endtask

    task automatic issue0(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        op0 = op; addr0 = a; wdata0 = d; sel0 = s;
        tick();
        op0 = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        op2 = 2'b00; addr2 = '0; wdata2 = '0; sel2 = '0;
        op0 = 2'b00; addr0 = '0; wdata0 = '0; sel0 = '0;

        // Reset held three cycles
        tick(); tick(); tick();
        check("rst_rdy2",  64'(rdy2),   64'd0);
        check("rst_data2", 64'(rdata2), 64'd0);
        check("rst_rdy0",  64'(rdy0),   64'd0);
        check("rst_data0", 64'(rdata0), 64'd0);
        rst_n = 1'b1;
        check("rel_rdy2_before_edge", 64'(rdy2), 64'd0);
        tick();
        check("rel_rdy2", 64'(rdy2), 64'd1);
        check("rel_rdy0", 64'(rdy0), 64'd1);

        // WAITCYCLES=2: full write then read
        txn2("wr5_full", 2'b01, 30'd5, 32'hDEADBEEF, 4'hF, 0, 32'h0);
        txn2("rd5_full", 2'b10, 30'd5, 32'h0, 4'h0, 2, 32'hDEADBEEF);

        // Byte-masked write; output must keep the previous read result
        txn2("wr5_mask", 2'b01, 30'd5, 32'h11223344, 4'b0101, 0, 32'hDEADBEEF);
        txn2("rd5_mask", 2'b10, 30'd5, 32'h0, 4'h0, 2, 32'hDE22BE44);

        // Swap returns the old word, then a read sees the new one
        txn2("rw5_swap", 2'b11, 30'd5, 32'h0, 4'hF, 2, 32'hDE22BE44);
        txn2("rd5_after_swap", 2'b10, 30'd5, 32'h0, 4'h0, 2, 32'h0);

        // Alias: upper address bits ignored
        txn2("wr_alias", 2'b01, 30'd1031, 32'hA5A50007, 4'hF, 0, 32'h0);
        txn2("rd_alias", 2'b10, 30'd7, 32'h0, 4'h0, 2, 32'hA5A50007);

        // Reset asserted during WAIT aborts the response
        txn2("rd5_prime", 2'b10, 30'd5, 32'h0, 4'h0, 2, 32'h0);
        issue2(2'b10, 30'd7, 32'h0, 4'h0);
        check("wait_rdy_low", 64'(rdy2), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_rdy",  64'(rdy2),   64'd0);
        tick();
        tick();
        check("midrst_rdy_held", 64'(rdy2), 64'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_rel_rdy",  64'(rdy2),   64'd1);
        check("midrst_no_resp",  64'(rdata2), 64'd0);
        // Array survives reset
        txn2("rd7_post_rst", 2'b10, 30'd7, 32'h0, 4'h0, 2, 32'hA5A50007);

        // WAITCYCLES=0: back-to-back writes keep rdy high
        for (int i = 1; i <= 4; i++) begin
            issue0(2'b01, AW'(i), 32'(i), 4'hF);
            check($sformatf("wr0_%0d_rdy", i), 64'(rdy0), 64'd1);
        end
        // Pipelined reads: one result per cycle, next cycle after accept
        op0 = 2'b10; sel0 = 4'h0; wdata0 = '0;
        for (int i = 1; i <= 3; i++) begin
            addr0 = AW'(i);
            tick();
            check($sformatf("rd0_%0d_data", i), 64'(rdata0), 64'(i));
            check($sformatf("rd0_%0d_rdy", i),  64'(rdy0),   64'd1);
        end
        op0 = 2'b00;
        tick();
        check("rd0_hold", 64'(rdata0), 64'd3);

        // Write-first: write then immediately read same index
        issue0(2'b01, 30'd4, 32'h00000044, 4'hF);
        issue0(2'b10, 30'd4, 32'h0, 4'h0);
        check("wf0_data", 64'(rdata0), 64'h44);
        // sel=0 write is a no-op
        issue0(2'b01, 30'd4, 32'hFFFFFFFF, 4'h0);
        check("sel0_hold", 64'(rdata0), 64'h44);
        issue0(2'b10, 30'd4, 32'h0, 4'h0);
        check("sel0_data", 64'(rdata0), 64'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
